// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root job path: default widths and the
// sequencer state encoding used by the sequencer, the root finder and benches.
package sqrt_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ROOT_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } sqrt_state_t;

endpackage

// File: rtl/sqrt_in_fifo.sv
// Small synchronous FIFO buffering radicands ahead of the job sequencer.
// Wrap-bit pointers; the head entry is visible without a pop.
module sqrt_in_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_empty = (wr_ptr_reg == rd_ptr_reg);

    // in_ready depends only on stored state, so a same-cycle pop never
    // opens a slot for a full FIFO.
    assign wr_ready = !full;
    assign do_push  = wr_valid && !full;
    assign do_pop   = rd_pop && !rd_empty;
    assign rd_data  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sqrt_job_sequencer.sv
// Feeds buffered radicands one at a time to the root finder, then checks
// each returned root and presents the result on a valid/ready port.
module sqrt_job_sequencer
    import sqrt_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ROOT_W     = ROOT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sqrt_start,
    output logic [DATA_W-1:0] sqrt_radicand,
    input  logic              sqrt_done,
    input  logic [ROOT_W-1:0] sqrt_root,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_radicand,
    output logic [ROOT_W-1:0] out_root,
    output logic [ROOT_W:0]   out_rem,
    output logic              out_err,
    output logic              out_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sqrt_state_t       state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              sqrt_start_reg;
    logic [DATA_W-1:0] sqrt_radicand_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_radicand_reg;
    logic [ROOT_W-1:0] out_root_reg;
    logic [ROOT_W:0]   out_rem_reg;
    logic              out_err_reg;
    logic              out_timeout_reg;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_pop;

    sqrt_in_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (in_valid),
        .wr_data  (in_data),
        .wr_ready (in_ready),
        .rd_pop   (fifo_pop),
        .rd_data  (fifo_head),
        .rd_empty (fifo_empty)
    );

    // The head was already copied into sqrt_radicand on entry to ISSUE.
    assign fifo_pop = (state_reg == ST_ISSUE);

    // Root check: root^2 <= radicand < (root+1)^2. The upper bound uses one
    // extra bit so the largest root (all ones) squares without wrapping.
    logic [DATA_W-1:0] root_ext;
    logic [DATA_W-1:0] root_sq;
    logic [DATA_W:0]   root_p1;
    logic [DATA_W:0]   root_p1_sq;
    logic              root_bad;
    logic [ROOT_W:0]   rem_next;

    always_comb begin
        root_ext   = DATA_W'(sqrt_root);
        root_sq    = root_ext * root_ext;
        root_p1    = (DATA_W+1)'(sqrt_root) + (DATA_W+1)'(1);
        root_p1_sq = root_p1 * root_p1;
        root_bad   = (root_sq > sqrt_radicand_reg) ||
                     (root_p1_sq <= {1'b0, sqrt_radicand_reg});
        rem_next   = sqrt_radicand_reg[ROOT_W:0] - root_sq[ROOT_W:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            sqrt_start_reg    <= 1'b0;
            sqrt_radicand_reg <= '0;
            out_valid_reg     <= 1'b0;
            out_radicand_reg  <= '0;
            out_root_reg      <= '0;
            out_rem_reg       <= '0;
            out_err_reg       <= 1'b0;
            out_timeout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        // Radicand is presented together with the start pulse.
                        sqrt_start_reg    <= 1'b1;
                        sqrt_radicand_reg <= fifo_head;
                        state_reg         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sqrt_start_reg <= 1'b0;
                    cnt_reg        <= '0;
                    state_reg      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (sqrt_done) begin
                        out_valid_reg    <= 1'b1;
                        out_radicand_reg <= sqrt_radicand_reg;
                        out_root_reg     <= sqrt_root;
                        out_rem_reg      <= rem_next;
                        out_err_reg      <= root_bad;
                        out_timeout_reg  <= 1'b0;
                        state_reg        <= ST_HOLD;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        out_valid_reg    <= 1'b1;
                        out_radicand_reg <= sqrt_radicand_reg;
                        out_root_reg     <= '0;
                        out_rem_reg      <= '0;
                        out_err_reg      <= 1'b1;
                        out_timeout_reg  <= 1'b1;
                        state_reg        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sqrt_start    = sqrt_start_reg;
    assign sqrt_radicand = sqrt_radicand_reg;
    assign out_valid     = out_valid_reg;
    assign out_radicand  = out_radicand_reg;
    assign out_root      = out_root_reg;
    assign out_rem       = out_rem_reg;
    assign out_err       = out_err_reg;
    assign out_timeout   = out_timeout_reg;

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Scoreboard bench for sqrt_job_sequencer with a behavioural root-finder model
// that replies from a queue of directed answers.
module tb_sqrt_job_sequencer;
    import sqrt_pkg::*;

    localparam int DW = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          sqrt_start;
    logic [DW-1:0] sqrt_radicand;
    logic          sqrt_done;
    logic [RW-1:0] sqrt_root;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_radicand;
    logic [RW-1:0] out_root;
    logic [RW:0]   out_rem;
    logic          out_err;
    logic          out_timeout;

    logic          model_done = 1'b0;
    logic [RW-1:0] model_root = '0;
    logic          stray_done = 1'b0;
    logic [RW-1:0] stray_root = '0;

    assign sqrt_done = model_done | stray_done;
    assign sqrt_root = stray_done ? stray_root : model_root;

    always #5 clk = ~clk;

    sqrt_job_sequencer #(
        .DATA_W     (DW),
        .ROOT_W     (RW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .sqrt_start    (sqrt_start),
        .sqrt_radicand (sqrt_radicand),
        .sqrt_done     (sqrt_done),
        .sqrt_root     (sqrt_root),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_radicand  (out_radicand),
        .out_root      (out_root),
        .out_rem       (out_rem),
        .out_err       (out_err),
        .out_timeout   (out_timeout)
    );

    typedef struct packed {
        logic [DW-1:0] rad;
        logic [RW-1:0] root;
        logic [RW:0]   rem;
        logic          err;
        logic          to;
    } result_t;

    typedef struct {
        int            delay;
        logic [RW-1:0] root;
        logic [DW-1:0] rad;
        bit            never;
    } reply_t;

    result_t exp_q[$];
    reply_t  reply_q[$];
    int      n_vec = 0;
    int      n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Result monitor: compares every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            result_t act;
            result_t exp;
            act = {out_radicand, out_root, out_rem, out_err, out_timeout};
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                exp = exp_q.pop_front();
                $display("result rad=%0d root=%0d rem=0x%0h err=%0b timeout=%0b",
                         out_radicand, out_root, out_rem, out_err, out_timeout);
                check("result", 64'(act), 64'(exp));
            end
        end
    end

    // The start pulse must never last a second cycle.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset && prev_start) begin
            check("start_width", 64'(sqrt_start), 64'(0));
        end
        prev_start = sqrt_start && !reset;
    end

    // Root-finder model: one reply per observed start pulse.
    initial begin
        reply_t r;
        forever begin
            @(negedge clk);
            if (sqrt_start && !reset) begin
                if (reply_q.size() == 0) begin
                    fail_now("start_without_job");
                end else begin
                    r = reply_q.pop_front();
                    check("sqrt_radicand", 64'(sqrt_radicand), 64'(r.rad));
                    if (!r.never) begin
                        repeat (r.delay) @(posedge clk);
                        #1;
                        check("radicand_held", 64'(sqrt_radicand), 64'(r.rad));
                        model_root = r.root;
                        model_done = 1'b1;
                        @(posedge clk);
                        #1;
                        model_done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic add_job(input logic [DW-1:0] rad, input logic [RW-1:0] root, input int delay,
                           input bit never, input bit expect_out, input logic [RW:0] rem,
                           input logic err, input logic to);
        reply_t r;
        r.delay = delay;
        r.root  = root;
        r.rad   = rad;
        r.never = never;
        reply_q.push_back(r);
        if (expect_out) begin
            exp_q.push_back({rad, (to ? 8'd0 : root), rem, err, to});
        end
    endtask

    // Call aligned just after a rising edge; returns aligned the same way.
    task automatic push(input logic [DW-1:0] d);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) fail_now("push_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sqrt_start && n < 200);
        if (!sqrt_start) fail_now("wait_start");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({sqrt_start, sqrt_radicand, out_valid, out_radicand, out_root, out_rem,
                   out_err, out_timeout}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic stray_pulse(input logic [RW-1:0] r);
        logic seen;
        @(posedge clk);
        #1;
        stray_root = r;
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid | sqrt_start;
        end
        check("stray_done_ignored", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({sqrt_start, sqrt_radicand, out_valid, out_radicand, out_root, out_rem,
                   out_err, out_timeout}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // 1: perfect square, start two cycles after acceptance
        add_job(16'd144, 8'd12, 5, 0, 1, 9'd0, 1'b0, 1'b0);
        push(16'd144);
        wait_start(n);
        check("start_latency", 64'(n), 64'(2));
        @(posedge clk);
        #1;
        drain();

        // 2: largest radicand, then a wrong root (10 - 16 modulo 2^9 = 0x1FA)
        add_job(16'd65535, 8'd255, 3, 0, 1, 9'd510, 1'b0, 1'b0);
        add_job(16'd10, 8'd4, 3, 0, 1, 9'h1FA, 1'b1, 1'b0);
        push(16'd65535);
        push(16'd10);
        drain();

        // 3: fill the FIFO behind a stalled result, then drain in order
        out_ready = 1'b0;
        add_job(16'd100, 8'd10, 2, 0, 1, 9'd0,  1'b0, 1'b0);
        add_job(16'd200, 8'd14, 2, 0, 1, 9'd4,  1'b0, 1'b0);
        add_job(16'd300, 8'd17, 2, 0, 1, 9'd11, 1'b0, 1'b0);
        add_job(16'd400, 8'd20, 2, 0, 1, 9'd0,  1'b0, 1'b0);
        add_job(16'd500, 8'd22, 2, 0, 1, 9'd16, 1'b0, 1'b0);
        add_job(16'd600, 8'd24, 2, 0, 1, 9'd24, 1'b0, 1'b0);
        push(16'd100);
        push(16'd200);
        push(16'd300);
        push(16'd400);
        push(16'd500);
        @(negedge clk);
        check("fifo_full_in_ready", 64'(in_ready), 64'(0));
        repeat (20) @(negedge clk);
        check("hold_stall_in_ready", 64'(in_ready), 64'(0));
        check("hold_stall_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(16'd600);
        drain();

        // 4: finder never answers -> timeout after 64 WAIT cycles
        add_job(16'd1234, 8'd0, 0, 1, 1, 9'd0, 1'b1, 1'b1);
        push(16'd1234);
        wait_start(n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        check("timeout_latency", 64'(n), 64'(65));
        @(posedge clk);
        #1;
        drain();

        // 5a: reset while waiting on the finder
        add_job(16'd77, 8'd0, 0, 1, 0, 9'd0, 1'b0, 1'b0);
        push(16'd77);
        wait_start(n);
        repeat (3) @(posedge clk);
        pulse_reset();
        stray_pulse(8'd9);

        // 5b: reset while a result is held
        out_ready = 1'b0;
        add_job(16'd25, 8'd5, 2, 0, 0, 9'd0, 1'b0, 1'b0);
        push(16'd25);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        check("hold_reached", 64'(out_valid), 64'(1));
        pulse_reset();
        out_ready = 1'b1;
        stray_pulse(8'd5);

        // 6: spurious done in IDLE, then radicand zero
        stray_pulse(8'd3);
        add_job(16'd0, 8'd0, 2, 0, 1, 9'd0, 1'b0, 1'b0);
        push(16'd0);
        drain();
        check("replies_consumed", 64'(reply_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
